// File: rtl/ram_sdp_pipe_clr.sv
// Simple dual-port RAM with byte strobes, a READ_LATENCY-deep read pipeline and a post-reset clear sequencer.
// Define RAM_RDW_FORWARD_EN for write-first collisions; leave it undefined for read-first.
module ram_sdp_pipe_clr #(
  parameter int                     ADDR_WIDTH     = 9,
  parameter int                     DATA_WIDTH     = 32,
  parameter int                     BYTE_WIDTH     = 8,
  parameter int                     READ_LATENCY   = 2,
  parameter int                     CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE    = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wr_strobe,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               rd_en,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  output logic                               init_busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    busy;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   we_addr;
  logic [DATA_WIDTH-1:0]   we_data;
  logic [NB-1:0]           we_mask;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic                    pv [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

  // State register and clear counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign init_busy = busy;
  assign wr_acc    = rst_n && wr_en && !busy;
  assign rd_acc    = rst_n && rd_en && !busy;

  // Single write port shared by the clear sequencer and user writes
  always_comb begin
    we_addr = wr_addr;
    we_data = wr_data;
    we_mask = '0;
    if (rst_n) begin
      if (busy) begin
        we_addr = clr_cnt;
        we_data = CLEAR_VALUE;
        we_mask = '1;
      end else if (wr_en) begin
        we_mask = wr_strobe;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (we_mask[i]) mem[we_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= we_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Memory is sampled at the request edge, so later writes never reach an in-flight read
  always_comb begin
    rd_word = mem[rd_addr];
`ifdef RAM_RDW_FORWARD_EN
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr_acc && wr_strobe[i] && (wr_addr == rd_addr))
        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
`endif
  end

  // Last stage only loads on a valid beat so rd_data holds between reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < READ_LATENCY; k++) begin
        pv[k] <= 1'b0;
        pd[k] <= '0;
      end
    end else begin
      pv[0] <= rd_acc;
      if (READ_LATENCY > 1 || rd_acc) pd[0] <= rd_word;
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        pv[k] <= pv[k-1];
        if (k < READ_LATENCY - 1 || pv[k-1]) pd[k] <= pd[k-1];
      end
    end
  end

  assign rd_valid = pv[READ_LATENCY-1];
  assign rd_data  = pd[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_sdp_pipe_clr.sv
// Bench for ram_sdp_pipe_clr: four latency variants plus a no-clear variant share one stimulus stream.
// Collision expectations follow RAM_RDW_FORWARD_EN as defined for the build.
module tb_ram_sdp_pipe_clr;

  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_strobe;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [8:0]  rd_addr;

  logic [31:0] rdd [4];
  logic        rdv [4];
  logic        bsy [4];
  logic [31:0] ncl_d;
  logic        ncl_v;
  logic        ncl_b;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_lat
    ram_sdp_pipe_clr #(
      .ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_WIDTH(8),
      .READ_LATENCY(g + 1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rdd[g]), .rd_valid(rdv[g]), .init_busy(bsy[g])
    );
  end

  ram_sdp_pipe_clr #(
    .ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .CLEAR_ON_RESET(0), .CLEAR_VALUE(CV)
  ) u_noclr (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(ncl_d), .rd_valid(ncl_v), .init_busy(ncl_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: memory contents, per-edge read log, remaining busy cycles
  logic [31:0] mdl_mem [512];
  logic        iss [8192];
  logic [31:0] dat [8192];
  logic [31:0] last_d [4];
  int          n        = 0;
  int          last_rst = 0;
  int          busy_left = 0;
  bit          chk_on   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, n);
    end
  endtask

  task automatic set_in(input logic we, input logic [3:0] st, input logic [8:0] wa,
                        input logic [31:0] wd, input logic re, input logic [8:0] ra);
    wr_en = we; wr_strobe = st; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  task automatic set_rand(input int unsigned amax);
    set_in(1'($urandom), 4'($urandom), 9'($urandom_range(0, amax)), $urandom,
           1'($urandom), 9'($urandom_range(0, amax)));
  endtask

  task automatic step();
    logic [31:0] w;
    @(posedge clk);
    n++;
    iss[n] = 1'b0;
    dat[n] = '0;
    if (!rst_n) begin
      busy_left = 512;
      last_rst  = n;
      chk_on    = 1;
      for (int i = 0; i < 512; i++) mdl_mem[i] = CV;
      for (int l = 0; l < 4; l++) last_d[l] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (rd_en) begin
        w = mdl_mem[rd_addr];
`ifdef RAM_RDW_FORWARD_EN
        if (wr_en && wr_addr == rd_addr)
          for (int b = 0; b < 4; b++) if (wr_strobe[b]) w[b*8 +: 8] = wr_data[b*8 +: 8];
`endif
        iss[n] = 1'b1;
        dat[n] = w;
      end
      if (wr_en)
        for (int b = 0; b < 4; b++) if (wr_strobe[b]) mdl_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
    end
    #1;
    if (chk_on) begin
      chk("init_busy", 32'(bsy[0]), 32'(busy_left > 0));
      chk("noclr_busy", 32'(ncl_b), 32'd0);
      for (int l = 0; l < 4; l++) begin
        int  idx;
        logic ev;
        idx = n - l;
        ev  = (idx > last_rst) && iss[idx];
        if (ev) last_d[l] = dat[idx];
        chk($sformatf("rd_valid_L%0d", l + 1), 32'(rdv[l]), 32'(ev));
        chk($sformatf("rd_data_L%0d", l + 1), rdd[l], last_d[l]);
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  st;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [8:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t tab [10];

  initial begin
    logic [31:0] col_exp;
`ifdef RAM_RDW_FORWARD_EN
    col_exp = 32'h0000FFFF;
`else
    col_exp = 32'h00000000;
`endif
    tab[0] = '{1'b0, 4'h0, 9'd0, 32'h0,        1'b1, 9'd0,   CV};
    tab[1] = '{1'b0, 4'h0, 9'd0, 32'h0,        1'b1, 9'd255, CV};
    tab[2] = '{1'b0, 4'h0, 9'd0, 32'h0,        1'b1, 9'd511, CV};
    tab[3] = '{1'b1, 4'hF, 9'd7, 32'h11223344, 1'b0, 9'd0,   32'h0};
    tab[4] = '{1'b1, 4'h5, 9'd7, 32'hAABBCCDD, 1'b0, 9'd0,   32'h0};
    tab[5] = '{1'b0, 4'h0, 9'd0, 32'h0,        1'b1, 9'd7,   32'h11BB33DD};
    tab[6] = '{1'b1, 4'hF, 9'd3, 32'h00000000, 1'b0, 9'd0,   32'h0};
    tab[7] = '{1'b1, 4'h3, 9'd3, 32'hFFFFFFFF, 1'b1, 9'd3,   col_exp};
    tab[8] = '{1'b0, 4'h0, 9'd0, 32'h0,        1'b1, 9'd3,   32'h0000FFFF};
    tab[9] = '{1'b0, 4'h0, 9'd0, 32'h0,        1'b0, 9'd0,   32'h0};

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // No-clear variant accepts a write on the very first cycle after release
    rst_n = 1'b1;
    set_in(1, 4'hF, 9'd5, 32'hDEADBEEF, 0, 0);
    step();
    set_in(0, 0, 0, 0, 1, 9'd5);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("noclr_first_wr_valid", 32'(ncl_v), 32'd1);
    chk("noclr_first_wr_data", ncl_d, 32'hDEADBEEF);

    while (busy_left > 0) step();

    for (int i = 0; i < 10; i++) begin
      set_in(tab[i].we, tab[i].st, tab[i].wa, tab[i].wd, tab[i].re, tab[i].ra);
      step();
      if (i > 0 && tab[i-1].re) begin
        chk($sformatf("tab%0d_valid", i - 1), 32'(rdv[1]), 32'd1);
        chk($sformatf("tab%0d_data", i - 1), rdd[1], tab[i-1].exp);
      end
    end

    // Reset at clear cycle 100, then busy traffic must be ignored
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin set_rand(511); step(); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 512; i++) begin
      set_rand(511);
      step();
    end
    chk("busy_done", 32'(bsy[0]), 32'd0);

    for (int i = 0; i < 512; i++) begin
      set_in(0, 0, 0, 0, 1, 9'(i));
      step();
    end

    for (int i = 0; i < 8; i++) begin
      set_in(1, 4'hF, 9'(i), 32'h01010101 * (i + 1), 0, 0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 0, 1, 9'(i));
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (5) step();

    for (int i = 0; i < 1500; i++) begin set_rand(15); step(); end
    for (int i = 0; i < 500; i++) begin set_rand(511); step(); end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
